// File: rtl/legv8_enc_pkg.sv
// Shared constants for the LEGv8 instruction encoder/loader.
// Op classes, decoder opcode patterns, error codes and FSM states.
package legv8_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_LSL  = 4'd4,
    OP_LSR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_SUBI = 4'd7,
    OP_LDUR = 4'd8,
    OP_STUR = 4'd9,
    OP_CBZ  = 4'd10,
    OP_B    = 4'd11,
    OP_MOVZ = 4'd12
  } op_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: symbolic LEGv8 instruction fields to a 32-bit word,
// with illegal-op and immediate range flags.
module legv8_field_pack
  import legv8_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  logic fit_shamt, fit_imm12, fit_imm16, fit_addr9, fit_imm19, fit_imm26;

  // signed fields fit when every bit above the sign bit copies it
  assign fit_shamt = (imm[31:6] == '0);
  assign fit_imm12 = (imm[31:12] == '0);
  assign fit_imm16 = (imm[31:16] == '0);
  assign fit_addr9 = (imm[31:8] == '0) || (imm[31:8] == '1);
  assign fit_imm19 = (imm[31:18] == '0) || (imm[31:18] == '1);
  assign fit_imm26 = (imm[31:25] == '0) || (imm[31:25] == '1);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (op)
      OP_ADD:  word = {OPC_ADD, rm, 6'd0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'd0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'd0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'd0, rn, rd};
      OP_LSL: begin
        word      = {OPC_LSL, 5'd0, imm[5:0], rn, rd};
        range_err = !fit_shamt;
      end
      OP_LSR: begin
        word      = {OPC_LSR, 5'd0, imm[5:0], rn, rd};
        range_err = !fit_shamt;
      end
      OP_ADDI: begin
        word      = {OPC_ADDI, imm[11:0], rn, rd};
        range_err = !fit_imm12;
      end
      OP_SUBI: begin
        word      = {OPC_SUBI, imm[11:0], rn, rd};
        range_err = !fit_imm12;
      end
      OP_LDUR: begin
        word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        range_err = !fit_addr9;
      end
      OP_STUR: begin
        word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        range_err = !fit_addr9;
      end
      OP_CBZ: begin
        word      = {OPC_CBZ, imm[18:0], rd};
        range_err = !fit_imm19;
      end
      OP_B: begin
        word      = {OPC_B, imm[25:0]};
        range_err = !fit_imm26;
      end
      OP_MOVZ: begin
        word      = {OPC_MOVZ, rm[1:0], imm[15:0], rd};
        range_err = !fit_imm16;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// LEGv8 program loader: accepts symbolic instructions, encodes them and
// writes the words to consecutive instruction-memory addresses.
//
// state    | meaning
// ST_IDLE  | ready for the next instruction
// ST_WRITE | encoded word presented on the write port, waiting for wr_ready
// ST_FULL  | MAX_WORDS written, only start or reset leaves
module instr_encoder_loader
  import legv8_enc_pkg::*;
#(
  parameter int AW        = 16,
  parameter int MAX_WORDS = 256,
  parameter int CW        = 9
) (
  input  logic          CLK,
  input  logic          resetl,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [31:0]   in_imm,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err,
  output logic [1:0]    err_code
);

  state_e        state, state_nxt;
  logic [31:0]   pack_word;
  logic          pack_illegal, pack_range;
  logic          accept, accept_ok, done;
  logic [CW-1:0] count_inc;

  legv8_field_pack u_pack (
    .op        (in_op),
    .rd        (in_rd),
    .rn        (in_rn),
    .rm        (in_rm),
    .imm       (in_imm),
    .word      (pack_word),
    .illegal   (pack_illegal),
    .range_err (pack_range)
  );

  assign in_ready  = (state == ST_IDLE) && !start;
  assign accept    = in_valid && in_ready;
  assign accept_ok = accept && !pack_illegal && !pack_range;
  assign wr_valid  = (state == ST_WRITE);
  assign done      = wr_valid && wr_ready;
  assign count_inc = count + CW'(1);
  assign full      = (count == CW'(MAX_WORDS));

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_ok) state_nxt = ST_WRITE;
      ST_WRITE: if (done) state_nxt = (count_inc == CW'(MAX_WORDS)) ? ST_FULL : ST_IDLE;
      ST_FULL:  state_nxt = ST_FULL;
      default:  state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (start) begin
      wr_addr  <= base_addr & ~AW'(3);
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (accept_ok) wr_data <= pack_word;
      // only the first error since start is reported in err_code
      if (accept && !accept_ok) begin
        err <= 1'b1;
        if (!err) err_code <= pack_illegal ? ERR_ILLEGAL : ERR_RANGE;
      end
      if (done) begin
        wr_addr <= wr_addr + AW'(4);
        count   <= count_inc;
      end
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Sequential LEGv8 instruction encoder and program loader, the inverse of the control decoder. It accepts symbolic instructions over a valid/ready handshake: an op class, register fields and an immediate. It range-checks them, packs them into the 32-bit machine word using the opcode patterns the decoder recognises, and writes the words into instruction memory at consecutive word addresses. It is used by benches and boot logic to build programs for the single-cycle processor.

Parameters:
AW, 16, instruction memory byte-address width
MAX_WORDS, 256, program capacity in words; count saturates here
CW, 9, width of count (must hold MAX_WORDS)

Ports:
CLK  input  1  clock, rising edge
resetl  input  1  asynchronous active-low reset
start  input  1  pulse: load base_addr, clear count/err/full, abort pending write
base_addr  input  AW  first byte address (low 2 bits ignored, forced 00)
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept
in_op  input  4  0 ADD,1 SUB,2 AND,3 ORR,4 LSL,5 LSR,6 ADDI,7 SUBI,8 LDUR,9 STUR,10 CBZ,11 B,12 MOVZ,13-15 illegal
in_rd  input  5  Rd/Rt
in_rn  input  5  Rn
in_rm  input  5  Rm; for MOVZ, bits [1:0] = hw
in_imm  input  32  signed immediate/offset/shamt
wr_valid  output  1  memory write request
wr_ready  input  1  memory accepts write
wr_addr  output  AW  byte address of write
wr_data  output  32  encoded instruction
count  output  CW  words written since start
full  output  1  count == MAX_WORDS
err  output  1  sticky error
err_code  output  2  0 none, 1 illegal op, 2 immediate out of range

Behaviour:
- Reset, asynchronous: state IDLE; wr_valid=0, wr_addr=0, wr_data=0, count=0, full=0, err=0, err_code=0.
- States are IDLE, WRITE and FULL. in_ready = (state==IDLE) && !start.
- IDLE, on in_valid&&in_ready:
  - Legal op with a fitting immediate: register the encoded word into wr_data, go to WRITE. wr_valid is high from the next cycle.
  - Otherwise: no write; err=1; err_code latches the first error only; stay IDLE. The entry is dropped.
- WRITE:
  - wr_valid=1. wr_addr and wr_data are held stable until wr_valid&&wr_ready.
  - On that edge: wr_valid=0, wr_addr+=4 (wraps mod 2^AW), count+=1.
  - Next state is FULL if the new count==MAX_WORDS, else IDLE.
- FULL: in_ready=0 and full=1. Only start or reset leaves FULL.
- Throughput is one word per 2 cycles with wr_ready tied high. Latency is 1 cycle from accept to wr_valid.
- start has priority in every state and takes effect at the edge:
  - wr_addr={base_addr[AW-1:2],2'b00}, count=0, full=0, err=0, err_code=0, state IDLE.
  - A pending write is abandoned (wr_valid drops).
  - in_valid is not accepted in the start cycle.
- Encodings (fields MSB:LSB):
  - R-format, op[31:21] Rm[20:16] shamt[15:10] Rn[9:5] Rd[4:0]:
    - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000; shamt=0.
    - LSL 11010011011, LSR 11010011010; Rm=0, shamt=in_imm[5:0].
  - I-format, op[31:22] imm12[21:10] Rn Rd: ADDI 1001000100, SUBI 1101000100.
  - D-format, op[31:21] addr9[20:12] 00 Rn Rt: LDUR 11111000010, STUR 11111000000.
  - CBZ: 10110100[31:24] imm19[23:5] Rt.
  - B: 000101[31:26] imm26[25:0].
  - MOVZ: 110100101[31:23] hw[22:21] imm16[20:5] Rd.
- Range rules, violation gives err_code 2:
  - Unsigned, must fit exactly: shamt 0..63, imm12 0..4095, imm16 0..65535.
  - Signed, must fit two's complement: addr9 -256..255, imm19, imm26.
  - Unused register fields are ignored.

Decomposition:
- Package legv8_enc_pkg holds:
  - op enum constants 0-12;
  - 11/10/9/8/6-bit opcode constants matching the decoder's patterns;
  - err_code constants;
  - state encoding.
- One combinational sub-module, legv8_field_pack: inputs op/rd/rn/rm/imm, outputs word[31:0], illegal and range_err.
- The top level holds the FSM, address/count registers and the handshake.

Test Plan:
- Reset, start base_addr=0x100, ADD rd=1 rn=2 rm=3 -> wr_valid next cycle, wr_addr=0x100, wr_data=0x8B030041, count=1.
- Then LDUR rd=5 rn=6 imm=-8 -> wr_addr=0x104, wr_data=0xF85F80C5; B imm=-1 -> wr_addr=0x108, wr_data=0x17FFFFFF.
- wr_ready held low 3 cycles during a write -> wr_valid/wr_addr/wr_data stable, in_ready=0, count unchanged until the handshake edge.
- ADDI imm=4096 -> no wr_valid, err=1, err_code=2, count unchanged; then op=14 -> err_code stays 2.
- MAX_WORDS=2: two writes -> full=1, in_ready=0 with in_valid held; start base_addr=0 -> full=0, count=0, next write at 0x0.
- start asserted while wr_valid high with wr_ready=0 -> wr_valid drops next cycle, count=0, no write recorded; resetl low mid-WRITE -> all outputs 0 immediately.
